// File: rtl/clr_mpram_if.sv
// Bus bundle for clr_mpram: write ports, registered read ports and bulk-clear handshake.
// The master drives addresses, data and clr_req. The slave (the RAM) drives read data and status.
interface clr_mpram_if #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int N_WRITE = 3,
  parameter int N_READ  = 3
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [N_WRITE-1:0]                 w_en;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [N_WRITE-1:0][WIDTH-1:0]      w_data;
  logic                               w_ready;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  r_addr;
  logic [N_READ-1:0][WIDTH-1:0]       r_data;
  logic                               clr_req;
  logic                               clr_busy;
  logic                               clr_done;

  modport master (
    output w_en, w_addr, w_data, r_addr, clr_req,
    input  w_ready, r_data, clr_busy, clr_done
  );

  modport slave (
    input  w_en, w_addr, w_data, r_addr, clr_req,
    output w_ready, r_data, clr_busy, clr_done
  );
endinterface

// File: rtl/clr_mpram.sv
// Multi-port flop register array with registered reads, optional write-first forwarding
// and a self-initialising bulk-clear sweep (N_WRITE entries per cycle).
//
//  state | meaning
//  IDLE  | normal operation, writes accepted, reads return stored data
//  CLEAR | sweeping CLEAR_VALUE from cnt upward, writes dropped, reads return CLEAR_VALUE
module clr_mpram #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 64,
  parameter int               N_WRITE     = 3,
  parameter int               N_READ      = 3,
  parameter int               BYPASS      = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic        clk,
  input logic        reset,
  clr_mpram_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          clr_done_q, clr_done_d;
  logic [N_READ-1:0][WIDTH-1:0]  r_data_q, r_data_d;
  logic [WIDTH-1:0]              mem_q [DEPTH];
  logic [WIDTH-1:0]              mem_d [DEPTH];
  logic                          busy;

  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    mem_d      = mem_q;
    r_data_d   = '0;

    if (busy) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (a >= int'(cnt_q) && a < int'(cnt_q) + N_WRITE) mem_d[a] = CLEAR_VALUE;
      end
      cnt_d = cnt_q + CW'(N_WRITE);
      if (int'(cnt_q) + N_WRITE >= DEPTH) begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end
    end else begin
      // Ascending port order lets the highest-index writer win on an address conflict.
      for (int i = 0; i < N_WRITE; i++) begin
        if (bus.w_en[i] && int'(bus.w_addr[i]) < DEPTH) mem_d[bus.w_addr[i]] = bus.w_data[i];
      end
      if (bus.clr_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end

    // mem_d already holds this cycle's committed writes, so it doubles as the bypass path.
    for (int j = 0; j < N_READ; j++) begin
      if (busy || int'(bus.r_addr[j]) >= DEPTH) r_data_d[j] = CLEAR_VALUE;
      else if (BYPASS != 0)                     r_data_d[j] = mem_d[bus.r_addr[j]];
      else                                      r_data_d[j] = mem_q[bus.r_addr[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      r_data_q   <= {N_READ{CLEAR_VALUE}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      r_data_q   <= r_data_d;
    end
  end

  // Storage is left out of reset; the sweep that reset starts defines its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.w_ready  = !busy;
  assign bus.clr_busy = busy;
  assign bus.clr_done = clr_done_q;
  assign bus.r_data   = r_data_q;
endmodule

// File: tb/tb_clr_mpram.sv
// Directed bench for clr_mpram: four geometries/configs exercised with hand-computed expectations.
module tb_clr_mpram;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  clr_mpram_if #(.WIDTH(16), .DEPTH(64), .N_WRITE(3), .N_READ(3)) if0 ();
  clr_mpram_if #(.WIDTH(16), .DEPTH(64), .N_WRITE(3), .N_READ(3)) if1 ();
  clr_mpram_if #(.WIDTH(16), .DEPTH(60), .N_WRITE(3), .N_READ(3)) if2 ();
  clr_mpram_if #(.WIDTH(16), .DEPTH(10), .N_WRITE(4), .N_READ(2)) if3 ();

  clr_mpram #(.WIDTH(16), .DEPTH(64), .N_WRITE(3), .N_READ(3), .BYPASS(1), .CLEAR_VALUE(16'h0000))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  clr_mpram #(.WIDTH(16), .DEPTH(64), .N_WRITE(3), .N_READ(3), .BYPASS(0), .CLEAR_VALUE(16'h00FF))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  clr_mpram #(.WIDTH(16), .DEPTH(60), .N_WRITE(3), .N_READ(3), .BYPASS(1), .CLEAR_VALUE(16'h0000))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  clr_mpram #(.WIDTH(16), .DEPTH(10), .N_WRITE(4), .N_READ(2), .BYPASS(1), .CLEAR_VALUE(16'h0000))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, nd, bad;
    if0.w_en = '0; if0.w_addr = '0; if0.w_data = '0; if0.r_addr = '0; if0.clr_req = 1'b0;
    if1.w_en = '0; if1.w_addr = '0; if1.w_data = '0; if1.r_addr = '0; if1.clr_req = 1'b0;
    if2.w_en = '0; if2.w_addr = '0; if2.w_data = '0; if2.r_addr = '0; if2.clr_req = 1'b0;
    if3.w_en = '0; if3.w_addr = '0; if3.w_data = '0; if3.r_addr = '0; if3.clr_req = 1'b0;

    // Reset state
    step(); step();
    check_val("rst_busy",    32'(if0.clr_busy), 32'd1);
    check_val("rst_ready",   32'(if0.w_ready),  32'd0);
    check_val("rst_done",    32'(if0.clr_done), 32'd0);
    check_val("rst_rdata0",  32'(if0.r_data[0]), 32'h0);
    check_val("rst_rdata2",  32'(if0.r_data[2]), 32'h0);
    check_val("rst_rdata_cv", 32'(if1.r_data[1]), 32'h00FF);

    // Reset sweep length and done pulse
    reset = 1'b0;
    nb = 0; nd = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (if0.clr_busy) nb++;
      if (if0.w_ready == if0.clr_busy) bad++;
      if (if0.clr_done && if0.clr_busy) bad++;
      if (if0.clr_done) nd++;
      step();
    end
    check_val("sweep_busy_cycles", 32'(nb),  32'd22);
    check_val("sweep_done_pulses", 32'(nd),  32'd1);
    check_val("sweep_ready_busy",  32'(bad), 32'd0);

    bad = 0;
    for (int a = 0; a < 64; a++) begin
      if0.r_addr[0] = 6'(a);
      step();
      if (if0.r_data[0] !== 16'h0) bad++;
    end
    check_val("sweep_all_zero", 32'(bad), 32'd0);

    // Reset at sweep cycle 10 restarts the sweep
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check_val("midrst_busy10", 32'(if0.clr_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (if0.clr_busy) nb++;
      if (if0.clr_done) nd++;
      step();
    end
    check_val("midrst_busy_cycles", 32'(nb), 32'd22);
    check_val("midrst_done_pulses", 32'(nd), 32'd1);

    // Conflict and bypass: if0 write-first, if1 read-first
    if0.w_en = 3'b001; if0.w_addr[0] = 6'd5; if0.w_data[0] = 16'h7777;
    if1.w_en = 3'b001; if1.w_addr[0] = 6'd5; if1.w_data[0] = 16'h7777;
    step();
    if0.w_en = 3'b111; if0.w_addr = {3{6'd5}}; if0.w_data = {16'h3333, 16'h2222, 16'h1111};
    if1.w_en = 3'b111; if1.w_addr = {3{6'd5}}; if1.w_data = {16'h3333, 16'h2222, 16'h1111};
    if0.r_addr[0] = 6'd5; if0.r_addr[1] = 6'd6;
    if1.r_addr[0] = 6'd5; if1.r_addr[1] = 6'd6;
    step();
    if0.w_en = '0; if1.w_en = '0;
    check_val("byp1_conflict", 32'(if0.r_data[0]), 32'h3333);
    check_val("byp1_other",    32'(if0.r_data[1]), 32'h0000);
    check_val("byp0_old",      32'(if1.r_data[0]), 32'h7777);
    check_val("byp0_other",    32'(if1.r_data[1]), 32'h00FF);
    step();
    check_val("byp0_new",      32'(if1.r_data[0]), 32'h3333);
    check_val("byp1_hold",     32'(if0.r_data[0]), 32'h3333);

    // Dropped writes on DEPTH=60: one during the sweep, one out of range
    if2.clr_req = 1'b1;
    step();
    if2.clr_req = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check_val("drop_ready_low", 32'(if2.w_ready), 32'd0);
    if2.w_en = 3'b001; if2.w_addr[0] = 6'd9; if2.w_data[0] = 16'hBEEF;
    step();
    if2.w_en = '0;
    for (int c = 0; c < 30 && if2.clr_busy; c++) step();
    check_val("drop_idle", 32'(if2.clr_busy), 32'd0);
    if2.w_en = 3'b110;
    if2.w_addr[1] = 6'd62; if2.w_data[1] = 16'hBEEF;
    if2.w_addr[2] = 6'd20; if2.w_data[2] = 16'h1234;
    step();
    if2.w_en = '0;
    if2.r_addr[0] = 6'd9; if2.r_addr[1] = 6'd62; if2.r_addr[2] = 6'd20;
    step();
    check_val("drop_busy_wr", 32'(if2.r_data[0]), 32'h0000);
    check_val("drop_oob_wr",  32'(if2.r_data[1]), 32'h0000);
    check_val("drop_good_wr", 32'(if2.r_data[2]), 32'h1234);

    // Runtime clear on if1 (CLEAR_VALUE 0x00FF, read-first)
    for (int a = 0; a < 64; a += 3) begin
      for (int p = 0; p < 3; p++) begin
        if1.w_en[p]   = (a + p < 64);
        if1.w_addr[p] = 6'((a + p) % 64);
        if1.w_data[p] = 16'(a + p) ^ 16'hA5A5;
      end
      step();
    end
    if1.w_en = '0;
    if1.r_addr[0] = 6'd42; if1.r_addr[1] = 6'd63;
    step();
    check_val("fill_42", 32'(if1.r_data[0]), 32'hA58F);
    check_val("fill_63", 32'(if1.r_data[1]), 32'hA59A);
    if1.clr_req = 1'b1;
    if1.w_en = 3'b001; if1.w_addr[0] = 6'd3; if1.w_data[0] = 16'hCAFE;
    step();
    if1.clr_req = 1'b0; if1.w_en = '0;
    check_val("rtclr_busy",  32'(if1.clr_busy), 32'd1);
    check_val("rtclr_ready", 32'(if1.w_ready),  32'd0);
    if1.r_addr[2] = 6'd42;
    step();
    check_val("rtclr_read_busy", 32'(if1.r_data[2]), 32'h00FF);
    for (int c = 0; c < 4; c++) step();
    if1.clr_req = 1'b1;
    step();
    if1.clr_req = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (if1.clr_busy) nb++;
      if (if1.clr_done) nd++;
      step();
    end
    check_val("rtclr_remaining", 32'(nb), 32'd16);
    check_val("rtclr_done",      32'(nd), 32'd1);
    bad = 0;
    for (int a = 0; a < 64; a += 3) begin
      for (int p = 0; p < 3; p++) if1.r_addr[p] = 6'((a + p) % 64);
      step();
      for (int p = 0; p < 3; p++) if (a + p < 64 && if1.r_data[p] !== 16'h00FF) bad++;
    end
    check_val("rtclr_all_cv", 32'(bad), 32'd0);

    // Odd geometry DEPTH=10, N_WRITE=4
    for (int a = 0; a < 10; a += 4) begin
      for (int p = 0; p < 4; p++) begin
        if3.w_en[p]   = 1'b1;
        if3.w_addr[p] = 4'(a + p);
        if3.w_data[p] = (a + p < 10) ? 16'(16'h0100 + a + p) : 16'hDEAD;
      end
      step();
    end
    if3.w_en = '0;
    if3.r_addr[0] = 4'd9; if3.r_addr[1] = 4'd11;
    step();
    check_val("odd_fill_9", 32'(if3.r_data[0]), 32'h0109);
    check_val("odd_oob_11", 32'(if3.r_data[1]), 32'h0000);
    if3.clr_req = 1'b1;
    step();
    if3.clr_req = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (if3.clr_busy) nb++;
      if (if3.clr_done) nd++;
      step();
    end
    check_val("odd_busy_cycles", 32'(nb), 32'd3);
    check_val("odd_done",        32'(nd), 32'd1);
    bad = 0;
    for (int a = 0; a < 10; a += 2) begin
      if3.r_addr[0] = 4'(a); if3.r_addr[1] = 4'(a + 1);
      step();
      if (if3.r_data[0] !== 16'h0) bad++;
      if (if3.r_data[1] !== 16'h0) bad++;
    end
    check_val("odd_all_clear", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
